ssd_scan_driver: RTL and testbench

- Parametrised multi-digit seven-segment driver. It is the successor to the team's single-digit combinational decoder.
- Time-multiplexes DIGITS nibbles onto one shared segment bus with one-hot digit enables.
- Adds hex glyphs, leading-zero blanking, per-digit decimal points, selectable output polarity, and tear-free value updates at frame boundaries.
- Sits between the datapath (numeric values) and the board display pins.

---
 rtl/ssd_scan_driver.sv | 159 +++++++++++++++
 tb/tb_ssd_scan_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed multi-digit seven-segment driver.
// Nibbles of a captured value are scanned one digit at a time onto a shared
// segment bus. New values are held in a pending register and only reach the
// display at a frame boundary, so a frame never shows a mix of old and new digits.
module ssd_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int HEX_MODE   = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            segments,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic          POL      = (ACTIVE_LOW != 0);

    // Glyph table, bit order abcdefg with a in bit 6.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        if (HEX_MODE == 0 && n > 4'd9) g = 7'b0000000;
        return g;
    endfunction

    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_val_q, disp_val_d, pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     en_q, en_d;
    logic                  bnd_q, fd_q;
    logic                  div_wrap, boundary;

    // Refresh counter, digit index and the pending/display value registers.
    always_comb begin
        div_wrap     = (div_cnt_q == DIV_LAST);
        boundary     = div_wrap && (idx_q == IDX_LAST);
        div_cnt_d    = div_wrap ? '0 : div_cnt_q + 1'b1;
        idx_d        = idx_q;
        if (div_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (boundary) begin
            // A load on the boundary itself skips the pending stage.
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    // Next pin values for the digit currently selected by idx, with blanking.
    always_comb begin
        logic [DIGITS-1:0] zmask;
        logic              zacc;
        logic [3:0]        nib;
        logic              blank;
        zmask = '0;
        zacc  = 1'b1;
        nib   = '0;
        blank = 1'b0;
        en_d  = '0;
        dp_d  = 1'b0;
        // zmask[i]: digit i and every digit above it are zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zacc     = zacc & (disp_val_q[4*i +: 4] == 4'd0);
            zmask[i] = zacc;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                en_d[i] = 1'b1;
                nib     = disp_val_q[4*i +: 4];
                dp_d    = disp_dp_q[i];
                blank   = blank_lz && (i != 0) && zmask[i];
            end
        end
        seg_d = blank ? 7'b0000000 : decode(nib);
    end

    // State and output registers; frame_done is delayed twice so it lines up
    // with the pins showing digit 0, which lag the internal index by a cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            en_q         <= '0;
            bnd_q        <= 1'b0;
            fd_q         <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            en_q         <= en_d;
            bnd_q        <= boundary;
            fd_q         <= bnd_q;
        end
    end

    assign segments   = seg_q ^ {7{POL}};
    assign dp_out     = dp_q ^ POL;
    assign digit_en   = en_q ^ {DIGITS{POL}};
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: three instances (hex/active-high, decimal-only,
// hex/active-low) share the stimulus. Expected pin values for each frame are
// queued when the frame's content is known and popped cycle by cycle.
module tb_ssd_scan_driver;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] en;
        logic       fd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;

    logic [6:0] seg0, seg1, seg2;
    logic       dp0, dp1, dp2;
    logic [3:0] en0, en1, en2;
    logic       fd0, fd1, fd2;

    int n_chk = 0;
    int n_fail = 0;
    obs_t q [3][$];

    always #5 clk = ~clk;

    ssd_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .segments(seg0), .dp_out(dp0), .digit_en(en0), .frame_done(fd0));
    ssd_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(0)) u1 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .segments(seg1), .dp_out(dp1), .digit_en(en1), .frame_done(fd1));
    ssd_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1), .ACTIVE_LOW(1)) u2 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .segments(seg2), .dp_out(dp2), .digit_en(en2), .frame_done(fd2));

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    function automatic obs_t actual(input int i);
        case (i)
            0: return {seg0, dp0, en0, fd0};
            1: return {seg1, dp1, en1, fd1};
            default: return {seg2, dp2, en2, fd2};
        endcase
    endfunction

    // Queue the 16 pin cycles of one frame showing v/dp under blanking level blz.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp,
                              input logic blz, input logic fd_first);
        for (int k = 0; k < 16; k++) begin
            int d;
            logic [3:0] nib;
            logic nz, blank;
            obs_t e0, e1, e2;
            d = k / 4;
            nib = v[4*d +: 4];
            nz = 1'b0;
            for (int j = d; j < 4; j++) if (v[4*j +: 4] != 4'd0) nz = 1'b1;
            blank = blz && (d > 0) && !nz;
            e0.seg = blank ? 7'h00 : glyph(nib);
            e0.dp  = dp[d];
            e0.en  = 4'(1 << d);
            e0.fd  = (k == 0) && fd_first;
            e1 = e0;
            if (nib > 4'd9) e1.seg = 7'h00;
            e2 = e0;
            e2.seg = ~e0.seg;
            e2.dp  = ~e0.dp;
            e2.en  = ~e0.en;
            q[0].push_back(e0);
            q[1].push_back(e1);
            q[2].push_back(e2);
        end
    endtask

    // Pop and compare ncyc pin cycles, driving up to two loads at chosen cycles.
    task automatic drain_frame(input int ncyc,
                               input int la_k, input logic [15:0] la_v, input logic [3:0] la_dp,
                               input int lb_k, input logic [15:0] lb_v, input logic [3:0] lb_dp,
                               input logic blz_next);
        for (int k = 0; k < ncyc; k++) begin
            for (int i = 0; i < 3; i++) begin
                obs_t e, a;
                n_chk++;
                a = actual(i);
                if (q[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard u%0d k=%0d: no expected entry, got %b", i, k, a);
                end else begin
                    e = q[i].pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL pins u%0d k=%0d: got seg=%b dp=%b en=%b fd=%b, expected seg=%b dp=%b en=%b fd=%b",
                                 i, k, a.seg, a.dp, a.en, a.fd, e.seg, e.dp, e.en, e.fd);
                    end
                end
            end
            load = 1'b0;
            if (k == la_k) begin load = 1'b1; value = la_v; dp_in = la_dp; end
            if (k == lb_k) begin load = 1'b1; value = lb_v; dp_in = lb_dp; end
            if (k == 15) blank_lz = blz_next;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic check_reset_pins(input string name);
        obs_t e0, e2, a;
        e0 = {7'b0000000, 1'b0, 4'b0000, 1'b0};
        e2 = {7'b1111111, 1'b1, 4'b1111, 1'b0};
        for (int i = 0; i < 3; i++) begin
            a = actual(i);
            n_chk++;
            if (a !== ((i == 2) ? e2 : e0)) begin
                n_fail++;
                $display("FAIL %s u%0d: got %b, expected %b", name, i, a, (i == 2) ? e2 : e0);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
        repeat (3) @(negedge clk);
        check_reset_pins("reset_hold");
        load = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        // First frame after reset: disp cleared, load during reset ignored, no frame_done yet.
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
        drain_frame(16, -1, '0, '0, -1, '0, '0, 1'b0);
    endtask

    task automatic test_hex;
        push_frame(16'h0000, 4'h0, 1'b0, 1'b1);
        drain_frame(16, 5, 16'h3A90, 4'b0100, -1, '0, '0, 1'b0);
        push_frame(16'h3A90, 4'b0100, 1'b0, 1'b1);
        drain_frame(16, 2, 16'hF005, 4'b0001, -1, '0, '0, 1'b0);
        // u1 (decimal only) shows digit 3 = F blank.
        push_frame(16'hF005, 4'b0001, 1'b0, 1'b1);
        drain_frame(16, 9, 16'h0007, 4'b1000, -1, '0, '0, 1'b1);
    endtask

    task automatic test_blank_lz;
        push_frame(16'h0007, 4'b1000, 1'b1, 1'b1);
        drain_frame(16, 9, 16'h0000, 4'b0000, -1, '0, '0, 1'b1);
        push_frame(16'h0000, 4'b0000, 1'b1, 1'b1);
        drain_frame(16, 4, 16'h1111, 4'b0011, 8, 16'h2222, 4'b1100, 1'b0);
    endtask

    task automatic test_back_to_back;
        // Last pending load wins; boundary load goes straight in, next-cycle load waits a frame.
        push_frame(16'h2222, 4'b1100, 1'b0, 1'b1);
        drain_frame(16, 14, 16'h4444, 4'b0101, 15, 16'h5555, 4'b1010, 1'b0);
        push_frame(16'h4444, 4'b0101, 1'b0, 1'b1);
        drain_frame(16, -1, '0, '0, -1, '0, '0, 1'b0);
        push_frame(16'h5555, 4'b1010, 1'b0, 1'b1);
        drain_frame(16, -1, '0, '0, -1, '0, '0, 1'b0);
    endtask

    task automatic test_reset_midscan;
        push_frame(16'h5555, 4'b1010, 1'b0, 1'b1);
        drain_frame(7, 3, 16'h1234, 4'b1111, -1, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) q[i].delete();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_pins("reset_midscan");
        rst_n = 1'b1;
        @(negedge clk);
        // Scan restarts at digit 0 and the pending 1234 never appears.
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
        drain_frame(16, -1, '0, '0, -1, '0, '0, 1'b0);
        push_frame(16'h0000, 4'h0, 1'b0, 1'b1);
        drain_frame(16, -1, '0, '0, -1, '0, '0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_hex;
        test_blank_lz;
        test_back_to_back;
        test_reset_midscan;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
